// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode tags, result-stage state encoding and flag type
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int TAG_W     = 3;

    typedef enum logic [TAG_W-1:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOT = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic parity;
    } flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational zero/negative/parity flags for one result word
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    output flags_t           flags_o
);

    always_comb begin
        flags_o        = '0;
        flags_o.zero   = (data_i == '0);
        flags_o.neg    = data_i[WIDTH-1];
        flags_o.parity = ^data_i;
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - 2-entry skid buffer with stored flags and delivery counter; ALU_RESULT_STICKY_EN adds sticky_or
module alu_result_stage #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH,
    parameter int TAG_W = alu_pkg::TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic [CNT_W-1:0] result_cnt
`ifdef ALU_RESULT_STICKY_EN
    ,
    output logic [WIDTH-1:0] sticky_or
`endif
);

    import alu_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_state_e     state_q, state_d;
    logic             rd_ptr_q, wr_ptr_q;
    logic [WIDTH-1:0] data_q  [2];
    logic [TAG_W-1:0] tag_q   [2];
    flags_t           flags_q [2];
    logic [CNT_W-1:0] cnt_q;
    flags_t           wr_flags;
    logic             push, pop;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (push) state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_d = ST_FULL;
                else if (pop && !push) state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .data_i  (in_data),
        .flags_o (wr_flags)
    );

    // Flags are captured alongside the word so the head outputs never depend on in_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
                flags_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q]  <= in_data;
                tag_q[wr_ptr_q]   <= in_tag;
                flags_q[wr_ptr_q] <= wr_flags;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_data   = data_q[rd_ptr_q];
    assign out_tag    = tag_q[rd_ptr_q];
    assign out_zero   = flags_q[rd_ptr_q].zero;
    assign out_neg    = flags_q[rd_ptr_q].neg;
    assign out_parity = flags_q[rd_ptr_q].parity;
    assign result_cnt = cnt_q;

`ifdef ALU_RESULT_STICKY_EN
    logic [WIDTH-1:0] sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (push) begin
            sticky_q <= sticky_q | in_data;
        end
    end

    assign sticky_or = sticky_q;
`endif

endmodule
